// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader that writes 35-bit words into program RAM
// Holds the CPU while a frame is in flight and reports done or a sticky error code.
module prog_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter logic [19:0] TIMEOUT   = 20'd500000,
   parameter int          INSTR_W   = 35,
   parameter int          ADDR_W    = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_hold,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CNT,
      S_DATA,
      S_CSUM
   } state_t;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_CSUM    = 2'b01;
   localparam logic [1:0] CODE_FORMAT  = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT = 2'b11;

   state_t              state_q,    state_d;
   logic                in_ready_q, in_ready_d;
   logic                wr_en_q,    wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
   logic [INSTR_W-1:0]  wr_data_q,  wr_data_d;
   logic                hold_q,     hold_d;
   logic                done_q,     done_d;
   logic                err_q,      err_d;
   logic [1:0]          code_q,     code_d;
   logic [ADDR_W-1:0]   ptr_q,      ptr_d;
   logic [8:0]          left_q,     left_d;
   logic [2:0]          idx_q,      idx_d;
   logic [INSTR_W-1:0]  word_q,     word_d;
   logic [7:0]          csum_q,     csum_d;
   logic [19:0]         tmo_q,      tmo_d;
   logic                accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d    = state_q;
      in_ready_d = 1'b1;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      err_d      = err_q;
      code_d     = code_q;
      ptr_d      = ptr_q;
      left_d     = left_q;
      idx_d      = idx_q;
      word_d     = word_q;
      csum_d     = csum_q;

      // idle-gap counter only runs inside a frame
      if (state_q == S_IDLE || accept) begin
         tmo_d = 20'd0;
      end else begin
         tmo_d = tmo_q + 20'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && in_data == SYNC_BYTE) begin
               err_d   = 1'b0;
               code_d  = CODE_NONE;
               hold_d  = 1'b1;
               csum_d  = 8'd0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (accept) begin
               ptr_d   = ADDR_W'(in_data);
               csum_d  = csum_q ^ in_data;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (accept) begin
               left_d  = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
               csum_d  = csum_q ^ in_data;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               if (idx_q == 3'd0) begin
                  if (in_data[7:3] != 5'd0) begin
                     err_d   = 1'b1;
                     code_d  = CODE_FORMAT;
                     state_d = S_IDLE;
                  end else begin
                     word_d = INSTR_W'(in_data[2:0]);
                     idx_d  = 3'd1;
                  end
               end else if (idx_q == 3'd4) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = {word_q[INSTR_W-9:0], in_data};
                  ptr_d     = ptr_q + ADDR_W'(1);
                  left_d    = left_q - 9'd1;
                  idx_d     = 3'd0;
                  if (left_q == 9'd1) begin
                     state_d = S_CSUM;
                  end
               end else begin
                  word_d = {word_q[INSTR_W-9:0], in_data};
                  idx_d  = idx_q + 3'd1;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (in_data == csum_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d  = 1'b1;
                  code_d = CODE_CSUM;
               end
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // a stalled frame is abandoned; the CPU stays held
      if (state_q != S_IDLE && !accept && tmo_q == TIMEOUT - 20'd1) begin
         err_d   = 1'b1;
         code_d  = CODE_TIMEOUT;
         tmo_d   = 20'd0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= CODE_NONE;
         ptr_q      <= '0;
         left_q     <= 9'd0;
         idx_q      <= 3'd0;
         word_q     <= '0;
         csum_q     <= 8'd0;
         tmo_q      <= 20'd0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         code_q     <= code_d;
         ptr_q      <= ptr_d;
         left_q     <= left_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cpu_hold = hold_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = code_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the CPU program memory. It receives a framed byte stream from the host-link byte receiver and assembles 35-bit instruction words. It writes each word into the synchronous program RAM that the CPU fetch port reads asynchronously.
- While a load is in progress it holds the CPU. It reports completion or failure to the top level.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 20'd500000, maximum idle cycles between bytes inside a frame before the frame is aborted.
- INSTR_W, 35, instruction word width. Fixed at 35; five bytes per word.
- ADDR_W, 8, program memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available from the link receiver.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts the byte when in_valid && in_ready.
- wr_en  out  1  program RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_W  program RAM write address.
- wr_data  out  INSTR_W  program RAM write data.
- cpu_hold  out  1  stalls CPU instruction fetch. The CPU restarts at IP=0 when it falls.
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  one-cycle pulse on a successful frame.
- err  out  1  sticky error flag.
- err_code  out  2  01 = checksum, 10 = format, 11 = timeout, 00 = none.

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=0, busy=0, done=0, err=0, err_code=00.
  - in_ready goes to 1 on the first clock after reset release.
- Frame format: SYNC_BYTE, START_ADDR, COUNT, then N*5 data bytes, then CSUM.
  - N = COUNT, with COUNT=0 meaning 256.
  - Each word is sent MSB byte first. Byte0[2:0] holds instr[34:32]; bytes 1-4 hold instr[31:0].
  - CSUM = XOR of START_ADDR, COUNT and all data bytes.
- States: IDLE -> ADDR -> CNT -> DATA -> CSUM -> IDLE.
  - IDLE: non-SYNC bytes are discarded. On SYNC: clear err/err_code, set cpu_hold=1, go to ADDR.
  - ADDR: latch the pointer from START_ADDR, go to CNT.
  - CNT: latch the word counter, go to DATA.
  - DATA: byte index 0..4.
    - Byte index 0 with in_data[7:3] != 0 is a format error: no write for that word, go to IDLE.
    - On acceptance of byte 4, on the next cycle: wr_en=1, wr_addr=pointer, wr_data=assembled word.
    - Pointer increments mod 256, so the address wraps 8'hFF -> 8'h00. The counter decrements.
    - After the last word, go to CSUM.
  - CSUM:
    - Match: done=1 for one cycle, cpu_hold=0, go to IDLE.
    - Mismatch: err=1, err_code=01, cpu_hold stays 1, go to IDLE.
- Words already written are not rolled back. After any error, cpu_hold stays 1 until a later frame succeeds or reset is applied.
- Throughput:
  - in_ready=1 in every state after reset. One byte per cycle is accepted.
  - wr_en pulses never overlap, since 5 byte cycles separate consecutive words.
- Timeout:
  - A counter runs in every state except IDLE. It clears on each accepted byte.
  - When it reaches TIMEOUT: err=1, err_code=11, go to IDLE, cpu_hold stays 1.
- A SYNC_BYTE value received inside a frame is treated as data. It does not restart the frame.
- An error on a later frame overwrites err_code. A new SYNC clears err.
- done and wr_en are never high in the same cycle. done is issued in the cycle after CSUM acceptance.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, cpu_hold=0.

Test Plan:
- Single-word load:
  - Stimulus: A5, 10, 01, 02 00 00 00 2A, CSUM=10^01^02^2A=39.
  - Required: one wr_en with wr_addr=8'h10 and wr_data=35'h20000002A, then done pulse, cpu_hold 1->0, err=0.
- Wrap-around:
  - Stimulus: START=FE, COUNT=3, three valid words, correct CSUM.
  - Required: writes to FE, FF, 00 in order, then done.
- Checksum error:
  - Stimulus: same frame as the single-word load with CSUM=38.
  - Required: the write still occurs, err=1, err_code=01, no done, cpu_hold remains 1. A following good frame then clears err and drops cpu_hold.
- Format error:
  - Stimulus: first data byte 08.
  - Required: no wr_en, err_code=10, return to IDLE. Then A5 restarts the frame normally.
- Timeout:
  - Stimulus: set TIMEOUT=20 in the bench, send A5, 00, then hold in_valid=0.
  - Required: after 20 cycles err_code=11, busy=0, cpu_hold=1.
- Reset and garbage in IDLE:
  - Stimulus: assert reset_n=0 mid-DATA.
  - Required: all outputs at reset values asynchronously.
  - Stimulus: bytes 00, FF, 5A in IDLE.
  - Required: discarded, busy stays 0.
- COUNT=0:
  - Stimulus: COUNT=0 frame with 1280 data bytes.
  - Required: 256 writes covering every address, then done.
